// File: rtl/uart_packet_rx_if.sv
// Output-side bundle of uart_packet_rx: packet valid/ready handshake plus the
// one-cycle error strobes.
interface uart_packet_rx_if #(
  parameter int W_OUT = 16
) ();
  logic             m_valid;
  logic             m_ready;
  logic [W_OUT-1:0] m_data;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;

  modport master (
    output m_valid, m_data, frame_err, parity_err, overrun,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, frame_err, parity_err, overrun,
    output m_ready
  );
endinterface

// File: rtl/uart_packet_rx.sv
// Multi-frame UART receiver: assembles W_OUT/BITS_PER_WORD frames into one packet
// with parity/stop checking, glitch-rejecting start detection and valid/ready output.
module uart_packet_rx #(
  parameter int CLOCKS_PER_PULSE = 16,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_OUT            = 16,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  uart_packet_rx_if.master m_if
);

  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int CNT_W     = $clog2(CLOCKS_PER_PULSE);
  localparam int BIT_W     = $clog2(BITS_PER_WORD + 1);
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [1:0]               r_sync;
  logic                     r_rx_prev;
  logic [CNT_W-1:0]         r_cnt;
  logic [BIT_W-1:0]         r_bit_idx;
  logic [BITS_PER_WORD-1:0] r_shift;
  logic                     r_par;
  logic                     r_perr;
  logic                     r_sbad;
  logic [W_OUT-1:0]         r_words;
  logic [IDX_W-1:0]         r_word_idx;

  logic             w_rx_s;
  logic             w_fall;
  logic             w_tick;
  logic             w_last_stop;
  logic             w_frame_bad;
  logic [W_OUT-1:0] w_packet;

  assign w_rx_s      = r_sync[1];
  assign w_fall      = r_rx_prev & ~w_rx_s;
  assign w_tick      = (r_cnt == '0);
  assign w_last_stop = (r_state == S_STOP) && w_tick && (r_bit_idx == LAST_STOP);
  assign w_frame_bad = r_sbad | ~w_rx_s;

  // Packet image with the word just received dropped into its slot.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
    assign w_packet[gi*BITS_PER_WORD +: BITS_PER_WORD] =
      (r_word_idx == IDX_W'(gi)) ? r_shift : r_words[gi*BITS_PER_WORD +: BITS_PER_WORD];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_fall) w_next_state = S_START;
      S_START:     if (w_tick) w_next_state = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (w_tick && (r_bit_idx == LAST_DATA))
                     w_next_state = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (w_tick) w_next_state = S_STOP;
      S_STOP:      if (w_last_stop) w_next_state = w_frame_bad ? S_WAIT_HIGH : S_IDLE;
      S_WAIT_HIGH: if (w_rx_s) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync          <= 2'b11;
      r_rx_prev       <= 1'b1;
      r_cnt           <= '0;
      r_bit_idx       <= '0;
      r_shift         <= '0;
      r_par           <= 1'b0;
      r_perr          <= 1'b0;
      r_sbad          <= 1'b0;
      r_words         <= '0;
      r_word_idx      <= '0;
      m_if.m_valid    <= 1'b0;
      m_if.m_data     <= '0;
      m_if.frame_err  <= 1'b0;
      m_if.parity_err <= 1'b0;
      m_if.overrun    <= 1'b0;
    end else begin
      r_sync          <= {r_sync[0], rx};
      r_rx_prev       <= w_rx_s;
      m_if.frame_err  <= 1'b0;
      m_if.parity_err <= 1'b0;
      m_if.overrun    <= 1'b0;
      if (m_if.m_valid && m_if.m_ready) m_if.m_valid <= 1'b0;

      if (r_state == S_IDLE) begin
        if (w_fall) r_cnt <= CNT_HALF;
      end else begin
        r_cnt <= w_tick ? CNT_FULL : r_cnt - 1'b1;
      end

      if (w_tick) begin
        case (r_state)
          S_START: begin
            r_bit_idx <= '0;
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
            r_sbad    <= 1'b0;
          end
          S_DATA: begin
            r_shift   <= {w_rx_s, r_shift[BITS_PER_WORD-1:1]};
            r_par     <= r_par ^ w_rx_s;
            r_bit_idx <= (r_bit_idx == LAST_DATA) ? '0 : r_bit_idx + 1'b1;
          end
          S_PARITY: r_perr <= ((r_par ^ w_rx_s) != (PARITY == 2));
          S_STOP: begin
            r_bit_idx <= r_bit_idx + 1'b1;
            r_sbad    <= w_frame_bad;
          end
          default: ;
        endcase
      end

      // End of frame: report errors, or commit the word and maybe the packet.
      if (w_last_stop) begin
        m_if.frame_err  <= w_frame_bad;
        m_if.parity_err <= r_perr;
        if (w_frame_bad || r_perr) begin
          r_word_idx <= '0;
        end else begin
          r_words <= w_packet;
          if (r_word_idx == LAST_WORD) begin
            r_word_idx <= '0;
            if (!m_if.m_valid || m_if.m_ready) begin
              m_if.m_data  <= w_packet;
              m_if.m_valid <= 1'b1;
            end else begin
              m_if.overrun <= 1'b1;
            end
          end else begin
            r_word_idx <= r_word_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx: three instances (plain, even parity, two stop
// bits) driven from a vector table plus hand-written corner-case sequences.
module tb_uart_packet_rx;
  localparam int CPP = 16;
  localparam int NV  = 10;

  logic clk = 1'b0;
  logic rstn;
  logic rx  [3];
  logic rdy [3];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  uart_packet_rx_if #(.W_OUT(16)) bus0 ();
  uart_packet_rx_if #(.W_OUT(16)) bus1 ();
  uart_packet_rx_if #(.W_OUT(16)) bus2 ();
  assign bus0.m_ready = rdy[0];
  assign bus1.m_ready = rdy[1];
  assign bus2.m_ready = rdy[2];

  uart_packet_rx u0 (.clk(clk), .rstn(rstn), .rx(rx[0]), .m_if(bus0));
  uart_packet_rx #(.PARITY(1)) u1 (.clk(clk), .rstn(rstn), .rx(rx[1]), .m_if(bus1));
  uart_packet_rx #(.STOP_BITS(2)) u2 (.clk(clk), .rstn(rstn), .rx(rx[2]), .m_if(bus2));

  logic        mv [3];
  logic [15:0] md [3];
  logic        mfe[3];
  logic        mpe[3];
  logic        mov[3];
  assign {mv[0], md[0], mfe[0], mpe[0], mov[0]} = {bus0.m_valid, bus0.m_data, bus0.frame_err, bus0.parity_err, bus0.overrun};
  assign {mv[1], md[1], mfe[1], mpe[1], mov[1]} = {bus1.m_valid, bus1.m_data, bus1.frame_err, bus1.parity_err, bus1.overrun};
  assign {mv[2], md[2], mfe[2], mpe[2], mov[2]} = {bus2.m_valid, bus2.m_data, bus2.frame_err, bus2.parity_err, bus2.overrun};

  // Event counters per instance, sampled mid-cycle.
  int          n_acc [3] = '{0, 0, 0};
  int          n_vh  [3] = '{0, 0, 0};
  int          n_fe  [3] = '{0, 0, 0};
  int          n_pe  [3] = '{0, 0, 0};
  int          n_both[3] = '{0, 0, 0};
  int          n_ov  [3] = '{0, 0, 0};
  logic [15:0] last_acc[3] = '{16'h0, 16'h0, 16'h0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mv[k] && rdy[k]) begin
        n_acc[k]++;
        last_acc[k] = md[k];
      end
      if (mv[k])           n_vh[k]++;
      if (mfe[k])          n_fe[k]++;
      if (mpe[k])          n_pe[k]++;
      if (mfe[k] && mpe[k]) n_both[k]++;
      if (mov[k])          n_ov[k]++;
    end
  end

  int b_acc, b_vh, b_fe, b_pe, b_both, b_ov;

  task automatic snap(input int d);
    b_acc = n_acc[d]; b_vh = n_vh[d]; b_fe = n_fe[d];
    b_pe = n_pe[d]; b_both = n_both[d]; b_ov = n_ov[d];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_counts(input string tag, input int d, input int e_acc,
                              input int e_fe, input int e_pe, input int e_ov);
    check({tag, "_acc"}, n_acc[d] - b_acc, e_acc);
    check({tag, "_fe"},  n_fe[d] - b_fe, e_fe);
    check({tag, "_pe"},  n_pe[d] - b_pe, e_pe);
    check({tag, "_ov"},  n_ov[d] - b_ov, e_ov);
  endtask

  task automatic send_bit(input int d, input logic b);
    rx[d] = b;
    repeat (CPP) @(negedge clk);
  endtask

  // Instance 1 carries a parity bit, instance 2 a second stop bit.
  task automatic send_frame(input int d, input logic [7:0] data, input logic p, input logic [1:0] s);
    send_bit(d, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d, data[i]);
    if (d == 1) send_bit(d, p);
    send_bit(d, s[0]);
    if (d == 2) send_bit(d, s[1]);
    rx[d] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    int              dut;
    int              nfr;
    logic [3:0][7:0] d;
    logic [3:0]      par;
    logic [3:0][1:0] stp;
    int              e_acc;
    logic [15:0]     e_data;
    int              e_fe;
    int              e_pe;
    int              e_both;
  } vec_t;

  vec_t vecs[NV];

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t t;
    vecs[0] = '{0, 2, {8'h00, 8'h00, 8'h3C, 8'hA5}, 4'b0000, 8'hFF,         1, 16'h3CA5, 0, 0, 0};
    vecs[1] = '{0, 2, {8'h00, 8'h00, 8'hFF, 8'h00}, 4'b0000, 8'hFF,         1, 16'hFF00, 0, 0, 0};
    vecs[2] = '{0, 3, {8'h00, 8'h12, 8'h34, 8'h5A}, 4'b0000, 8'b11111110,   1, 16'h1234, 1, 0, 0};
    vecs[3] = '{0, 4, {8'h78, 8'h56, 8'h34, 8'h12}, 4'b0000, 8'b11111011,   1, 16'h7856, 1, 0, 0};
    vecs[4] = '{1, 3, {8'h00, 8'h12, 8'h34, 8'h07}, 4'b0010, 8'hFF,         1, 16'h1234, 0, 1, 0};
    vecs[5] = '{1, 2, {8'h00, 8'h00, 8'h7E, 8'h81}, 4'b0000, 8'hFF,         1, 16'h7E81, 0, 0, 0};
    vecs[6] = '{1, 3, {8'h00, 8'h3C, 8'hC3, 8'h01}, 4'b0000, 8'b11111110,   1, 16'h3CC3, 1, 1, 1};
    vecs[7] = '{1, 4, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b0010, 8'hFF,         1, 16'h4433, 0, 1, 0};
    vecs[8] = '{2, 2, {8'h00, 8'h00, 8'hBE, 8'hEF}, 4'b0000, 8'hFF,         1, 16'hBEEF, 0, 0, 0};
    vecs[9] = '{2, 3, {8'h00, 8'hF0, 8'h0F, 8'h55}, 4'b0000, 8'b11111110,   1, 16'hF00F, 1, 0, 0};

    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rx[k]  = 1'b1;
      rdy[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid",  bus0.m_valid, 0);
    check("rst_data",   bus0.m_data, 0);
    check("rst_fe",     bus0.frame_err, 0);
    check("rst_pe",     bus0.parity_err, 0);
    check("rst_ov",     bus0.overrun, 0);
    check("rst_valid1", bus1.m_valid, 0);
    check("rst_valid2", bus2.m_valid, 0);
    $display("[TB] reset applied");
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      t = vecs[v];
      snap(t.dut);
      for (int f = 0; f < t.nfr; f++) send_frame(t.dut, t.d[f], t.par[f], t.stp[f]);
      repeat (8) @(negedge clk);
      #1;
      $display("[TB] vec %0d dut %0d frames %0d -> data %h", v, t.dut, t.nfr, last_acc[t.dut]);
      check_counts($sformatf("vec%0d", v), t.dut, t.e_acc, t.e_fe, t.e_pe, 0);
      check($sformatf("vec%0d_data", v), last_acc[t.dut], t.e_data);
      check($sformatf("vec%0d_both", v), n_both[t.dut] - b_both, t.e_both);
      check($sformatf("vec%0d_vhigh", v), n_vh[t.dut] - b_vh, t.e_acc);
    end

    // Short low glitch must be ignored, then a normal packet follows.
    snap(0);
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    repeat (40) @(negedge clk);
    check_counts("glitch", 0, 0, 0, 0, 0);
    send_frame(0, 8'h34, 1'b0, 2'b11);
    send_frame(0, 8'h12, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    #1;
    $display("[TB] glitch then 1234 -> data %h", last_acc[0]);
    check_counts("glitch_pkt", 0, 1, 0, 0, 0);
    check("glitch_data", last_acc[0], 16'h1234);

    // Second stop low with the line held low afterwards; recovery once it rises.
    snap(2);
    send_bit(2, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(2, i[0]);
    send_bit(2, 1'b1);
    send_bit(2, 1'b0);
    repeat (3 * CPP) @(negedge clk);
    #1;
    check("whigh_fe",  n_fe[2] - b_fe, 1);
    check("whigh_acc", n_acc[2] - b_acc, 0);
    rx[2] = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(2, 8'hEF, 1'b0, 2'b11);
    send_frame(2, 8'hBE, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    #1;
    $display("[TB] wait_high recovery -> data %h", last_acc[2]);
    check_counts("whigh_pkt", 2, 1, 1, 0, 0);
    check("whigh_data", last_acc[2], 16'hBEEF);

    // Backpressure: second packet dropped with overrun, first one kept.
    rdy[0] = 1'b0;
    snap(0);
    send_frame(0, 8'h11, 1'b0, 2'b11);
    send_frame(0, 8'h11, 1'b0, 2'b11);
    #1;
    check("ovr_valid1", bus0.m_valid, 1);
    check("ovr_data1",  bus0.m_data, 16'h1111);
    send_frame(0, 8'h22, 1'b0, 2'b11);
    send_frame(0, 8'h22, 1'b0, 2'b11);
    #1;
    $display("[TB] overrun 1111/2222 -> data %h", bus0.m_data);
    check("ovr_data2", bus0.m_data, 16'h1111);
    check("ovr_count", n_ov[0] - b_ov, 1);
    @(posedge clk);
    #1 rdy[0] = 1'b1;
    @(negedge clk);
    #1 check("ovr_valid_hold", bus0.m_valid, 1);
    @(negedge clk);
    #1 check("ovr_valid_clear", bus0.m_valid, 0);
    check("ovr_acc", last_acc[0], 16'h1111);
    send_frame(0, 8'h33, 1'b0, 2'b11);
    send_frame(0, 8'h33, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    #1;
    $display("[TB] after overrun 3333 -> data %h", last_acc[0]);
    check("ovr_next", last_acc[0], 16'h3333);
    check("ovr_count_end", n_ov[0] - b_ov, 1);

    // Reset in the middle of a frame with a packet still held.
    rdy[0] = 1'b0;
    send_frame(0, 8'h5A, 1'b0, 2'b11);
    send_frame(0, 8'h5A, 1'b0, 2'b11);
    #1;
    check("mrst_pre_valid", bus0.m_valid, 1);
    check("mrst_pre_data",  bus0.m_data, 16'h5A5A);
    rx[0] = 1'b0;
    repeat (3 * CPP) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mrst_valid", bus0.m_valid, 0);
    check("mrst_data",  bus0.m_data, 0);
    check("mrst_fe",    bus0.frame_err, 0);
    check("mrst_pe",    bus0.parity_err, 0);
    check("mrst_ov",    bus0.overrun, 0);
    repeat (3) @(negedge clk);
    rx[0]  = 1'b1;
    rstn   = 1'b1;
    rdy[0] = 1'b1;
    repeat (10) @(negedge clk);
    snap(0);
    send_frame(0, 8'hFE, 1'b0, 2'b11);
    send_frame(0, 8'hCA, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    #1;
    $display("[TB] post-reset CAFE -> data %h", last_acc[0]);
    check_counts("mrst_pkt", 0, 1, 0, 0, 0);
    check("mrst_pkt_data", last_acc[0], 16'hCAFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_packet_rx.md
# uart_packet_rx

Parametrised UART receiver: the next generation of the receive side of `uart_main`. It deserialises `NUM_WORDS = W_OUT/BITS_PER_WORD` consecutive UART frames into one `W_OUT`-bit word. New over the current receiver:
- optional parity check and 1 or 2 stop bits;
- start-bit glitch rejection;
- framing, parity and overrun reporting;
- a valid/ready output handshake with backpressure.

It sits between the `rx` pin and the downstream consumer.

## Interface
- `CLOCKS_PER_PULSE`, 16: clk cycles per UART bit. Must be even and ≥ 4.
- `BITS_PER_WORD`, 8: data bits per frame.
- `W_OUT`, 16: output width. Must be an integer multiple of `BITS_PER_WORD`.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, idle high. Asynchronous to `clk`.
- `m_ready`  in  1  consumer accepts `m_data` when `m_valid` and `m_ready` are both high.
- `m_valid`  out  1  `m_data` holds a complete packet.
- `m_data`  out  W_OUT  assembled packet. First received word is in `[BITS_PER_WORD-1:0]`.
- `frame_err`  out  1  one-cycle pulse: a stop bit was sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch.
- `overrun`  out  1  one-cycle pulse: a packet completed while the output was still held, and the new packet was dropped.

## Operation
- `rx` passes through a 2-flop synchroniser. All sampling uses the synchronised value `rx_s`.
- States and transitions:
  - IDLE: a high→low transition on `rx_s` → START. The bit counter loads `CLOCKS_PER_PULSE/2-1`.
  - START: at count 0, sample `rx_s`. High = false start → IDLE, nothing reported. Low → DATA, counter reloads `CLOCKS_PER_PULSE-1`.
  - DATA: sample mid-bit every `CLOCKS_PER_PULSE` clks, LSB first, `BITS_PER_WORD` bits. Then → PARITY if `PARITY != 0`, otherwise → STOP.
  - PARITY: sample the parity bit. Even: XOR of the data bits and the parity bit must be 0. Odd: it must be 1.
  - STOP: sample `STOP_BITS` stop bits mid-bit.
    - All high and no parity error: the word is written to slot `word_idx`.
    - If `word_idx == NUM_WORDS-1`, the packet is complete and `word_idx` wraps to 0. Otherwise `word_idx` increments.
    - → IDLE immediately after the last stop sample, so back-to-back frames are accepted.
  - WAIT_HIGH: entered after a framing error. Stays until `rx_s` is high, then → IDLE.
- Errors:
  - Parity mismatch: `parity_err` pulses in the cycle after the last stop sample.
  - Any stop bit low: `frame_err` pulses, and the state → WAIT_HIGH instead of IDLE.
  - Either error discards the whole partial packet and resets `word_idx` to 0.
  - Both errors in the same frame: both flags pulse in the same cycle.
- Output handshake:
  - Packet completes while `m_valid` is 0: load `m_data`, set `m_valid`.
  - `m_valid` stays high and `m_data` stays stable until a cycle with `m_ready` high. `m_valid` clears on the next edge.
  - Packet completes while `m_valid` is 1 and `m_ready` is 0: `overrun` pulses, the new packet is dropped, and the old data is kept.
  - Packet completes while `m_valid` is 1 and `m_ready` is 1: the old packet is consumed, the new one is loaded, `m_valid` stays 1, and there is no overrun.
- Reset, including mid-frame: state IDLE, `word_idx` 0, synchroniser flops 1. All outputs are 0: `m_valid`, `m_data`, `frame_err`, `parity_err`, `overrun`.

## Timing
- Synchroniser latency: 2 clks from `rx` to `rx_s`.
- Start sample: `CLOCKS_PER_PULSE/2` clks after the falling edge is seen on `rx_s`. Each later sample is `CLOCKS_PER_PULSE` clks after the previous one.
- `m_valid`, `frame_err`, `parity_err` and `overrun` register 1 clk after the final stop-bit sample of the relevant frame.
- A low pulse on `rx_s` shorter than `CLOCKS_PER_PULSE/2` clks is a false start and produces no output.
- Minimum packet time: `NUM_WORDS*(1+BITS_PER_WORD+(PARITY!=0)+STOP_BITS)*CLOCKS_PER_PULSE` clks, minus half a bit per frame. This follows from the early return to IDLE after the stop sample.
- Sustained line rate is supported with `m_ready` tied high.

## Test plan
- Defaults, `m_ready`=1, frames 0xA5 then 0x3C at 16 clk/bit → `m_valid` high for 1 clk, `m_data`=0x3CA5. No error flags.
- Drive `rx` low for 4 clks, then high → no state change past START, no flags. A following packet 0x1234 (frames 0x34, 0x12) → `m_data`=0x1234.
- `PARITY`=1, frame 0x07 with parity bit 0 → `parity_err` pulse, no `m_valid`. Then frames 0x34/0x12 with correct parity → `m_data`=0x1234.
- `STOP_BITS`=2, second stop bit low → `frame_err` pulse, FSM holds in WAIT_HIGH while `rx` is low. After `rx` returns high, 0xBEEF is received correctly.
- `m_ready`=0, send 0x1111 then 0x2222 → `m_data` stays 0x1111 and `overrun` pulses once. Raise `m_ready` → `m_valid` clears after 1 clk. A further 0x3333 is delivered.
- Assert `rstn`=0 mid-DATA of the first word → all outputs 0. A packet 0xCAFE sent after release → `m_data`=0xCAFE.
